commit_trace_checker: RTL
=========================

# commit_trace_checker

Synthesizable commit-stream checker that consumes the retire events the processor hierarchy already exposes (register write, store, halt) and compares them in order against a golden event stream pushed in over a valid/ready port. It is the consuming end of the commit trace: the processor produces events, and this block buffers expected events, checks them cycle by cycle, counts retired instructions and latches the first failure. It sits beside `proc_hier` in simulation and FPGA bring-up builds.

## Interface
- `DEPTH`, 8: golden FIFO entries, power of two, ≥2
- `CNT_W`, 32: width of event/instruction counters
- `clk` in 1: sole clock, rising edge
- `rst_n` in 1: asynchronous assert, active-low reset; synchronous deassert handled upstream
- `commit_reg_wr` in 1: register-file write retiring this cycle
- `commit_reg_sel` in 3: written register
- `commit_reg_data` in 16: written value
- `commit_mem_wr` in 1: store retiring this cycle
- `commit_mem_addr` in 16: store address
- `commit_mem_data` in 16: store data
- `commit_halt` in 1: halt retiring this cycle
- `gold_valid` in 1: golden event offered
- `gold_ready` out 1: golden event accepted when `gold_valid & gold_ready`
- `gold_kind` in 2: 0 REG, 1 STORE, 2 HALT, 3 LOAD
- `gold_a` in 16: REG: `{13'b0, sel}`; STORE/LOAD: address; HALT: don't care
- `gold_d` in 16: data; HALT: don't care
- `done` out 1: HALT matched
- `fail` out 1: sticky failure
- `err_code` out 2: 0 none, 1 mismatch, 2 underflow, 3 protocol
- `fail_idx` out CNT_W: event index of first failure
- `fail_act_a`, `fail_act_d` out 16 each: actual address/sel and data at failure
- `inst_count` out CNT_W: matched events

## Operation
- FSM states: RUN (reset), DONE, FAIL. DONE and FAIL are terminal until reset.
- DUT event in a cycle = exactly one of `commit_reg_wr`, `commit_mem_wr`, `commit_halt`, or LOAD when `COMMIT_CHECK_LOAD_EN` is defined. Two or more asserted together → FAIL, `err_code`=3; FIFO is not popped.
- In RUN with one event: FIFO empty → FAIL, `err_code`=2. Otherwise compare the head entry and pop it. Kind, `a` and `d` must all match; HALT compares kind only.
- On match: `inst_count`+1. HALT match → DONE.
- On mismatch: FAIL, `err_code`=1.
- At any failure: `fail_idx` = `inst_count` value before the event; `fail_act_a`/`fail_act_d` capture the DUT values (HALT: 0).
- `gold_ready` = RUN & !full. In DONE/FAIL, golden pushes are refused and commits are ignored.
- Counters wrap modulo 2^CNT_W; there is no saturation.
- Leftover FIFO entries after DONE are not an error.

## Timing
- Reset values: `gold_ready`=1, `done`=0, `fail`=0, `err_code`=0, `fail_idx`=0, `fail_act_a`=0, `fail_act_d`=0, `inst_count`=0, FIFO empty.
- Reset mid-run clears everything immediately (asynchronous); the first compare takes place at the first rising edge after deassertion.
- There is no bypass: an entry pushed at edge N can first be compared at edge N+1. An event at edge N with the FIFO empty before that edge is an underflow, even if a push also lands at edge N.
- Push and pop at the same edge: occupancy is unchanged. A full FIFO (with `gold_ready` low) popped at edge N raises `gold_ready` after edge N.
- All status outputs are registered and update at the edge that samples the event. `gold_ready` is combinational from registered state only.

## Configuration
- `COMMIT_CHECK_LOAD_EN` defined:
  - Adds ports `commit_mem_rd` (in 1), `commit_rd_addr` (in 16) and `commit_rd_data` (in 16).
  - A load counts as an event and is compared against kind 3 (LOAD).
- Undefined:
  - These ports are absent.
  - A golden kind 3 reaching the head of the FIFO can never match. The first event then compares against it and fails with `err_code`=1.

## Structure
- Package `commit_trace_pkg`: kind encodings (REG/STORE/HALT/LOAD), err codes, FSM state enum, 34-bit golden entry struct `{kind, a, d}`.
- Sub-module `commit_fifo`: parameterized synchronous FIFO (DEPTH, entry width) with push/pop/full/empty and wrap-around pointers plus an extra bit.
- Top: FSM, comparator, counters and failure capture.

## Test plan
- **Match run:** push REG(3,0x1234), STORE(0x0040,0xBEEF), HALT; DUT retires the same three events → `inst_count`=3, `done`=1, `fail`=0.
- **Data mismatch:** golden REG(5,0x00FF), DUT writes r5=0x00FE as event 0 → `fail`=1, `err_code`=1, `fail_idx`=0, `fail_act_a`=5, `fail_act_d`=0x00FE. Later commits are ignored.
- **Underflow:** push nothing; DUT store to 0x0010 → `err_code`=2, `fail_idx`=0. Push and event at the same edge → still `err_code`=2.
- **Back-pressure:** push DEPTH entries with no commits → `gold_ready`=0. One matching commit → `gold_ready`=1 next cycle, and a push then succeeds.
- **Protocol error:** `commit_reg_wr` and `commit_mem_wr` asserted together → `err_code`=3 and the FIFO count is unchanged.
- **Reset mid-run:** after 2 matches, pulse `rst_n` low asynchronously between edges → all outputs return to reset values immediately and the FIFO is empty.

Source files
------------

// File: rtl/commit_trace_pkg.sv
// Shared encodings (event kinds, error codes, checker states) and the golden entry layout
// used by the commit trace checker and its FIFO.
package commit_trace_pkg;

   localparam logic [1:0] KIND_REG   = 2'd0;
   localparam logic [1:0] KIND_STORE = 2'd1;
   localparam logic [1:0] KIND_HALT  = 2'd2;
   localparam logic [1:0] KIND_LOAD  = 2'd3;

   localparam logic [1:0] ERR_NONE      = 2'd0;
   localparam logic [1:0] ERR_MISMATCH  = 2'd1;
   localparam logic [1:0] ERR_UNDERFLOW = 2'd2;
   localparam logic [1:0] ERR_PROTOCOL  = 2'd3;

   localparam logic [1:0] ST_RUN  = 2'd0;
   localparam logic [1:0] ST_DONE = 2'd1;
   localparam logic [1:0] ST_FAIL = 2'd2;

   typedef struct packed {
      logic [1:0]  kind;
      logic [15:0] a;
      logic [15:0] d;
   } gold_entry_t;

   localparam int GOLD_ENTRY_W = $bits(gold_entry_t);

   // HALT carries no payload, so only its kind takes part in the comparison.
   function automatic logic entry_match(gold_entry_t exp_e, gold_entry_t act_e);
      if (exp_e.kind != act_e.kind) return 1'b0;
      if (exp_e.kind == KIND_HALT) return 1'b1;
      return (exp_e.a == act_e.a) && (exp_e.d == act_e.d);
   endfunction

endpackage

// File: rtl/commit_fifo.sv
// Synchronous FIFO holding expected commit events; the head entry is visible combinationally
// so it can be compared in the same cycle a DUT event arrives.
module commit_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 34
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             push_en, pop_en;

   // Pointers carry one extra wrap bit to tell full from empty.
   always_comb begin
      full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      empty     = (wr_ptr_q == rd_ptr_q);
      push_en   = push && !full;
      pop_en    = pop && !empty;
      wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, push_en};
      rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, pop_en};
      head_data = mem_q[rd_ptr_q[AW-1:0]];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/commit_trace_checker.sv
// Compares retiring commit events against a buffered golden stream, counts matches and
// latches the first failure. Define COMMIT_CHECK_LOAD_EN to also check load events.
module commit_trace_checker
   import commit_trace_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             commit_reg_wr,
   input  logic [2:0]       commit_reg_sel,
   input  logic [15:0]      commit_reg_data,
   input  logic             commit_mem_wr,
   input  logic [15:0]      commit_mem_addr,
   input  logic [15:0]      commit_mem_data,
   input  logic             commit_halt,
`ifdef COMMIT_CHECK_LOAD_EN
   input  logic             commit_mem_rd,
   input  logic [15:0]      commit_rd_addr,
   input  logic [15:0]      commit_rd_data,
`endif
   input  logic             gold_valid,
   output logic             gold_ready,
   input  logic [1:0]       gold_kind,
   input  logic [15:0]      gold_a,
   input  logic [15:0]      gold_d,
   output logic             done,
   output logic             fail,
   output logic [1:0]       err_code,
   output logic [CNT_W-1:0] fail_idx,
   output logic [15:0]      fail_act_a,
   output logic [15:0]      fail_act_d,
   output logic [CNT_W-1:0] inst_count
);

   logic [1:0]       state_q, state_d;
   logic [1:0]       err_code_q, err_code_d;
   logic [CNT_W-1:0] fail_idx_q, fail_idx_d;
   logic [15:0]      fail_act_a_q, fail_act_a_d;
   logic [15:0]      fail_act_d_q, fail_act_d_d;
   logic [CNT_W-1:0] inst_count_q, inst_count_d;

   logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
   gold_entry_t      push_e, head_e, act_e;
   logic [2:0]       ev_cnt;

   assign push_e = '{kind: gold_kind, a: gold_a, d: gold_d};

   commit_fifo #(.DEPTH(DEPTH), .WIDTH(GOLD_ENTRY_W)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push),
      .push_data (push_e),
      .pop       (fifo_pop),
      .head_data (head_e),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Normalise whichever retire strobe fired into a golden-format entry.
   always_comb begin
      ev_cnt = {2'b0, commit_reg_wr} + {2'b0, commit_mem_wr} + {2'b0, commit_halt};
`ifdef COMMIT_CHECK_LOAD_EN
      ev_cnt = ev_cnt + {2'b0, commit_mem_rd};
`endif
      act_e = '{kind: KIND_HALT, a: 16'h0, d: 16'h0};
      if (commit_reg_wr)
         act_e = '{kind: KIND_REG, a: {13'b0, commit_reg_sel}, d: commit_reg_data};
      else if (commit_mem_wr)
         act_e = '{kind: KIND_STORE, a: commit_mem_addr, d: commit_mem_data};
`ifdef COMMIT_CHECK_LOAD_EN
      else if (commit_mem_rd)
         act_e = '{kind: KIND_LOAD, a: commit_rd_addr, d: commit_rd_data};
`endif
   end

   always_comb begin
      state_d      = state_q;
      err_code_d   = err_code_q;
      fail_idx_d   = fail_idx_q;
      fail_act_a_d = fail_act_a_q;
      fail_act_d_d = fail_act_d_q;
      inst_count_d = inst_count_q;
      fifo_pop     = 1'b0;

      gold_ready = (state_q == ST_RUN) && !fifo_full;
      fifo_push  = gold_valid && gold_ready;

      if ((state_q == ST_RUN) && (ev_cnt != 3'd0)) begin
         fail_idx_d   = inst_count_q;
         fail_act_a_d = act_e.a;
         fail_act_d_d = act_e.d;
         if (ev_cnt > 3'd1) begin
            state_d    = ST_FAIL;
            err_code_d = ERR_PROTOCOL;
         end else if (fifo_empty) begin
            state_d    = ST_FAIL;
            err_code_d = ERR_UNDERFLOW;
         end else begin
            fifo_pop = 1'b1;
            if (entry_match(head_e, act_e)) begin
               // Capture registers only hold meaningful values once a failure is latched.
               fail_idx_d   = fail_idx_q;
               fail_act_a_d = fail_act_a_q;
               fail_act_d_d = fail_act_d_q;
               inst_count_d = inst_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
               if (head_e.kind == KIND_HALT) state_d = ST_DONE;
            end else begin
               state_d    = ST_FAIL;
               err_code_d = ERR_MISMATCH;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_RUN;
         err_code_q   <= ERR_NONE;
         fail_idx_q   <= '0;
         fail_act_a_q <= '0;
         fail_act_d_q <= '0;
         inst_count_q <= '0;
      end else begin
         state_q      <= state_d;
         err_code_q   <= err_code_d;
         fail_idx_q   <= fail_idx_d;
         fail_act_a_q <= fail_act_a_d;
         fail_act_d_q <= fail_act_d_d;
         inst_count_q <= inst_count_d;
      end
   end

   assign done       = (state_q == ST_DONE);
   assign fail       = (state_q == ST_FAIL);
   assign err_code   = err_code_q;
   assign fail_idx   = fail_idx_q;
   assign fail_act_a = fail_act_a_q;
   assign fail_act_d = fail_act_d_q;
   assign inst_count = inst_count_q;

endmodule
